// File: rtl/fp_add_pkg.sv
// Shared constants and types for the single-precision adder pipeline.
// Contents: format widths, exponent limits, flag bit positions, special
// word constants, and the stage payload structs used by the
// post-normalize/round stage.
package fp_add_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int MANT_W  = FRAC_W + 4;   // hidden + fraction + guard/round/sticky
  localparam int E_W     = EXP_W + 2;    // signed working exponent, room for +/- excursions
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  // Bit positions inside the 4-bit flag vector {overflow, underflow, inexact, zero}
  localparam int FLAG_OVF  = 3;
  localparam int FLAG_UNF  = 2;
  localparam int FLAG_INX  = 1;
  localparam int FLAG_ZERO = 0;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] INF  = 32'h7F80_0000;

  // Stage 1 payload: normalized mantissa and adjusted exponent
  typedef struct packed {
    logic                  sign;
    logic signed [E_W-1:0] e;
    logic [MANT_W-1:0]     mant;
    logic                  zero;
    logic                  bypass;
    logic [31:0]           bword;
  } s1_t;

  // Stage 2 payload: packed result and flags
  typedef struct packed {
    logic [31:0] result;
    logic [3:0]  flags;
  } s2_t;

endpackage

// File: rtl/fp_add_norm_round_lzc27.sv
// Combinational 27-bit leading-zero counter.
// Ports:
//   a_i   [26:0] value to scan, MSB first
//   cnt_o [4:0]  number of leading zeros; 27 when a_i is zero
module lzc27 (
  input  logic [26:0] a_i,
  output logic [4:0]  cnt_o
);

  logic found;

  always_comb begin
    cnt_o = 5'd27;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && a_i[i]) begin
        cnt_o = 5'(26 - i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_add_norm_round.sv
// Post-normalization and round-to-nearest-even stage of the pipelined
// binary32 adder. Two registered stages with valid/ready backpressure:
// stage 1 finishes normalization (leading-zero shift, exponent adjust),
// stage 2 rounds, applies exponent limits and packs the result word.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         input handshake
//   in_sign, in_exp, in_mant  sum sign, biased exponent, 27-bit mantissa {h,frac,g,r,s}
//   in_ovf, in_shl1           upstream already shifted right / left by one
//   in_bypass, in_bypass_word special-case word emitted verbatim
//   out_valid/out_ready       output handshake
//   out_result, out_flags     packed word, {overflow, underflow, inexact, zero}
module fp_add_norm_round
  import fp_add_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  input  logic              in_ovf,
  input  logic              in_shl1,
  input  logic              in_bypass,
  input  logic [31:0]       in_bypass_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic [3:0]        out_flags
);

  localparam logic signed [E_W-1:0] E_TOP = E_W'(EXP_MAX);
  localparam logic signed [E_W-1:0] E_ONE = E_W'(1);

  logic       s1_valid_q, s1_valid_d;
  logic       s2_valid_q, s2_valid_d;
  s1_t        s1_q, s1_d;
  s2_t        s2_q, s2_d;
  logic       s2_load;
  logic [4:0] lzc;

  assign s2_load  = !s2_valid_q | out_ready;
  assign in_ready = !s1_valid_q | s2_load;

  lzc27 u_lzc (
    .a_i   (in_mant),
    .cnt_o (lzc)
  );

  // Stage 1: exponent pre-adjust and leading-zero normalization
  logic [E_W-1:0] e_u;
  logic           needs_shift;

  always_comb begin
    needs_shift = !in_mant[MANT_W-1] && (in_mant != '0);
    e_u = {2'b00, in_exp} + {{(E_W-1){1'b0}}, in_ovf} - {{(E_W-1){1'b0}}, in_shl1};
    s1_d        = '0;
    s1_d.sign   = in_sign;
    s1_d.mant   = in_mant;
    s1_d.bypass = in_bypass;
    s1_d.bword  = in_bypass_word;
    s1_d.zero   = (in_mant == '0) && !in_bypass;
    if (needs_shift) begin
      e_u       = e_u - {{(E_W-5){1'b0}}, lzc};
      s1_d.mant = in_mant << lzc;
    end
    s1_d.e = $signed(e_u);
  end

  // Stage 2: round to nearest even, limit checks, pack
  logic                  rnd_up;
  logic [24:0]           m24;
  logic signed [E_W-1:0] e_r;
  logic [FRAC_W-1:0]     frac;
  logic                  inexact;

  always_comb begin
    rnd_up  = s1_q.mant[2] & (s1_q.mant[1] | s1_q.mant[0] | s1_q.mant[3]);
    inexact = |s1_q.mant[2:0];
    m24     = {1'b0, s1_q.mant[MANT_W-1:3]} + {24'b0, rnd_up};
    // Carry out of rounding means the mantissa became 10.000..., renormalize by one
    e_r     = s1_q.e + $signed({{(E_W-1){1'b0}}, m24[24]});
    frac    = m24[24] ? m24[23:1] : m24[22:0];

    s2_d                 = '0;
    s2_d.result          = {s1_q.sign, e_r[EXP_W-1:0], frac};
    s2_d.flags[FLAG_INX] = inexact;
    if (s1_q.bypass) begin
      s2_d.result = s1_q.bword;
      s2_d.flags  = '0;
    end else if (s1_q.zero) begin
      s2_d.result           = 32'h0;
      s2_d.flags            = '0;
      s2_d.flags[FLAG_ZERO] = 1'b1;
    end else if (e_r >= E_TOP) begin
      s2_d.result          = {s1_q.sign, 8'hFF, 23'h0};
      s2_d.flags           = '0;
      s2_d.flags[FLAG_OVF] = 1'b1;
      s2_d.flags[FLAG_INX] = 1'b1;
    end else if (e_r < E_ONE) begin
      // Denormals are not produced; anything at or below zero flushes
      s2_d.result           = {s1_q.sign, 31'h0};
      s2_d.flags            = '0;
      s2_d.flags[FLAG_UNF]  = 1'b1;
      s2_d.flags[FLAG_ZERO] = 1'b1;
      s2_d.flags[FLAG_INX]  = 1'b1;
    end
  end

  always_comb begin
    s1_valid_d = in_ready ? in_valid : s1_valid_q;
    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_q       <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      // A bubble moving into stage 2 clears the output word so idle outputs read 0
      if (s2_load) s2_q <= s1_valid_q ? s2_d : '0;
    end
  end

  // Stage 1 data needs no reset: it is only observed behind s1_valid_q
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) s1_q <= s1_d;
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_q.result;
  assign out_flags  = s2_q.flags;

endmodule

// File: tb/tb_fp_add_norm_round.sv
module tb_fp_add_norm_round;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [26:0] in_mant;
  logic        in_ovf;
  logic        in_shl1;
  logic        in_bypass;
  logic [31:0] in_bypass_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_add_norm_round dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sign        (in_sign),
    .in_exp         (in_exp),
    .in_mant        (in_mant),
    .in_ovf         (in_ovf),
    .in_shl1        (in_shl1),
    .in_bypass      (in_bypass),
    .in_bypass_word (in_bypass_word),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_flags      (out_flags)
  );

  typedef struct {
    string       name;
    logic        sign;
    logic [7:0]  exp;
    logic [26:0] mant;
    logic        ovf;
    logic        shl1;
    logic        byp;
    logic [31:0] bword;
    logic [31:0] res;
    logic [3:0]  flags;
  } vec_t;

  localparam int NV = 13;
  vec_t vt[NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic setv(input int i, input string nm, input logic s, input logic [7:0] e,
                      input logic [26:0] m, input logic o, input logic l, input logic b,
                      input logic [31:0] bw, input logic [31:0] r, input logic [3:0] f);
    vt[i].name = nm;  vt[i].sign = s;  vt[i].exp = e;   vt[i].mant = m;
    vt[i].ovf = o;    vt[i].shl1 = l;  vt[i].byp = b;   vt[i].bword = bw;
    vt[i].res = r;    vt[i].flags = f;
  endtask

  task automatic drive(input int i);
    in_sign        = vt[i].sign;
    in_exp         = vt[i].exp;
    in_mant        = vt[i].mant;
    in_ovf         = vt[i].ovf;
    in_shl1        = vt[i].shl1;
    in_bypass      = vt[i].byp;
    in_bypass_word = vt[i].bword;
  endtask

  int  sent, got;
  logic hs_in, hs_out;

  initial begin
    // flags = {overflow, underflow, inexact, zero}
    setv(0,  "one_plus_one", 0, 8'd127, 27'h4000000, 1, 0, 0, 32'h0, 32'h40000000, 4'b0000);
    setv(1,  "cancel",       0, 8'd127, 27'h0000008, 0, 0, 0, 32'h0, 32'h34000000, 4'b0000);
    setv(2,  "tie_even",     0, 8'd127, 27'h4000004, 0, 0, 0, 32'h0, 32'h3F800000, 4'b0010);
    setv(3,  "tie_odd",      0, 8'd127, 27'h400000C, 0, 0, 0, 32'h0, 32'h3F800002, 4'b0010);
    setv(4,  "rnd_carry",    0, 8'd127, 27'h7FFFFFC, 0, 0, 0, 32'h0, 32'h40000000, 4'b0010);
    setv(5,  "overflow",     1, 8'd254, 27'h4000000, 1, 0, 0, 32'h0, 32'hFF800000, 4'b1010);
    setv(6,  "exact_zero",   1, 8'd127, 27'h0000000, 0, 0, 0, 32'h0, 32'h00000000, 4'b0001);
    setv(7,  "flush",        0, 8'd1,   27'h2000000, 0, 0, 0, 32'h0, 32'h00000000, 4'b0111);
    setv(8,  "bypass",       0, 8'd127, 27'h0000000, 0, 0, 1, 32'h7FC00000, 32'h7FC00000, 4'b0000);
    setv(9,  "shl1",         0, 8'd127, 27'h4000000, 0, 1, 0, 32'h0, 32'h3F000000, 4'b0000);
    setv(10, "round_up",     0, 8'd127, 27'h4000006, 0, 0, 0, 32'h0, 32'h3F800001, 4'b0010);
    setv(11, "neg_two",      1, 8'd128, 27'h4000000, 0, 0, 0, 32'h0, 32'hC0000000, 4'b0000);
    setv(12, "flush_neg",    1, 8'd1,   27'h2000000, 0, 0, 0, 32'h0, 32'h80000000, 4'b0111);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst out_valid",  out_valid, 0);
    chk("rst out_result", out_result, 0);
    chk("rst out_flags",  out_flags, 0);
    chk("rst in_ready",   in_ready, 1);

    // Single beats: present after edge k, captured at k+1, visible after k+2
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(i); in_valid = 1'b1; out_ready = 1'b1;
      #1 chk({vt[i].name, " in_ready"}, in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      chk({vt[i].name, " early"}, out_valid, 0);
      @(negedge clk);
      chk({vt[i].name, " valid"},  out_valid, 1);
      chk({vt[i].name, " result"}, out_result, vt[i].res);
      chk({vt[i].name, " flags"},  {28'h0, out_flags}, {28'h0, vt[i].flags});
    end
    @(negedge clk);
    @(negedge clk);
    chk("drained", out_valid, 0);

    // Five back-to-back beats with a three-cycle output stall
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      @(negedge clk);
      out_ready = !(cyc >= 2 && cyc <= 4);
      in_valid  = (sent < 5);
      if (sent < 5) drive(sent);
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        chk("bp in_ready low", in_ready, 0);
        chk("bp hold valid",   out_valid, 1);
        chk("bp hold result",  out_result, vt[0].res);
        chk("bp hold flags",   {28'h0, out_flags}, {28'h0, vt[0].flags});
      end
      hs_in  = in_valid & in_ready;
      hs_out = out_valid & out_ready;
      if (hs_out) begin
        if (got < 5) begin
          chk($sformatf("bp order %0d", got), out_result, vt[got].res);
          chk($sformatf("bp flags %0d", got), {28'h0, out_flags}, {28'h0, vt[got].flags});
        end
        got++;
      end
      @(posedge clk);
      if (hs_in) sent++;
    end
    in_valid = 1'b0;
    chk("bp beats out", got, 5);
    chk("bp beats in",  sent, 5);
    repeat (2) @(negedge clk);
    chk("bp no dup", out_valid, 0);

    // Reset with two beats in flight
    @(negedge clk);
    out_ready = 1'b0; drive(0); in_valid = 1'b1;
    @(negedge clk);
    drive(3);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("mid rst out_valid",  out_valid, 0);
    chk("mid rst out_result", out_result, 0);
    chk("mid rst out_flags",  out_flags, 0);
    chk("mid rst in_ready",   in_ready, 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("mid rst quiet %0d", k), out_valid, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
